// File: rtl/spi_bus_bridge_pkg.sv
// Shared types and frame-length helpers for the serial-to-register-bus bridge.
package spi_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RW    = 3'd2,
        WDATA = 3'd3,
        RWAIT = 3'd4,
        RESP  = 3'd5
    } state_t;

    function automatic int wr_frame_len(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

    function automatic int resp_len(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/spi_bus_bridge_if.sv
// Parallel register bus driven by the bridge (master) toward the register decode (slave).
interface spi_bus_bridge_if #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int ADDR_LSB = 2
);
    // bus_we/bus_re are single-cycle strobes qualified by bus_addr (and bus_wr_data);
    // bus_rd_data is only meaningful in a cycle where bus_rd_ack is high.
    logic [AW+ADDR_LSB-1:0] bus_addr;
    logic [DW-1:0]          bus_wr_data;
    logic                   bus_we;
    logic                   bus_re;
    logic [DW-1:0]          bus_rd_data;
    logic                   bus_rd_ack;

    modport master (
        output bus_addr, bus_wr_data, bus_we, bus_re,
        input  bus_rd_data, bus_rd_ack
    );

    modport slave (
        input  bus_addr, bus_wr_data, bus_we, bus_re,
        output bus_rd_data, bus_rd_ack
    );
endinterface

// File: rtl/spi_bus_tx.sv
// Load-and-shift response transmitter: start bit, DW data bits MSB first, status bit.
module spi_bus_tx
    import spi_bus_bridge_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          status,
    output logic          spi_dout,
    output logic          busy
);
    localparam int LEN = resp_len(DW);
    localparam int CW  = $clog2(LEN + 1);

    logic [LEN-1:0] r_sh;
    logic [CW-1:0]  r_cnt;

    // Zero fill on shift leaves the line low once the frame has gone out.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sh  <= {1'b1, data, status};
            r_cnt <= CW'(LEN);
        end else if (r_cnt != '0) begin
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign spi_dout = r_sh[LEN-1];
    assign busy     = (r_cnt != '0);

endmodule

// File: rtl/spi_bus_bridge.sv
// Serial command frames in, register bus strobes out; reads answered with a framed response.
module spi_bus_bridge
    import spi_bus_bridge_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int ADDR_LSB = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             spi_din,
    output logic             spi_dout,
    output logic             overrun,
    input  logic             overrun_clr,
    spi_bus_bridge_if.master bus,
    output state_t           o_dbg_state
);
    localparam int ACW = (AW > 1) ? $clog2(AW) : 1;
    localparam int DCW = $clog2(DW + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t                 r_state, w_state_nxt;
    logic [ACW-1:0]         r_acnt;
    logic [DCW-1:0]         r_dcnt;
    logic [WCW-1:0]         r_wcnt;
    logic [AW-1:0]          r_addr_sh;
    logic [DW-1:0]          r_data_sh;
    logic                   r_need_low;
    logic                   r_overrun;
    logic [AW+ADDR_LSB-1:0] r_bus_addr;
    logic [DW-1:0]          r_bus_wr_data;
    logic                   r_bus_we;
    logic                   r_bus_re;

    logic                   w_do_write;
    logic                   w_do_read;
    logic                   w_tx_load;
    logic [DW-1:0]          w_tx_data;
    logic                   w_tx_status;
    logic                   w_tx_busy;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_write  = 1'b0;
        w_do_read   = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_data   = '0;
        w_tx_status = 1'b0;
        case (r_state)
            IDLE:  if (spi_din && !r_need_low) w_state_nxt = ADDR;
            ADDR:  if (r_acnt == ACW'(AW - 1)) w_state_nxt = RW;
            RW: begin
                if (spi_din) begin
                    w_state_nxt = WDATA;
                end else begin
                    w_do_read   = 1'b1;
                    w_state_nxt = RWAIT;
                end
            end
            WDATA: begin
                if (r_dcnt == DCW'(DW - 1)) begin
                    w_do_write  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RWAIT: begin
                // An ack in the final wait cycle still beats the timeout.
                if (bus.bus_rd_ack) begin
                    w_tx_load   = 1'b1;
                    w_tx_data   = bus.bus_rd_data;
                    w_state_nxt = RESP;
                end else if (r_wcnt == WCW'(TIMEOUT)) begin
                    w_tx_load   = 1'b1;
                    w_tx_status = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    if (!w_tx_busy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_acnt        <= '0;
            r_dcnt        <= '0;
            r_wcnt        <= '0;
            r_addr_sh     <= '0;
            r_data_sh     <= '0;
            r_need_low    <= 1'b0;
            r_overrun     <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_bus_we      <= 1'b0;
            r_bus_re      <= 1'b0;
        end else begin
            r_bus_we <= 1'b0;
            r_bus_re <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_acnt <= '0;
                    r_dcnt <= '0;
                    if (!spi_din) r_need_low <= 1'b0;
                end
                ADDR: begin
                    r_addr_sh <= AW'({r_addr_sh, spi_din});
                    if (r_acnt != ACW'(AW - 1)) r_acnt <= r_acnt + 1'b1;
                end
                WDATA: begin
                    r_data_sh <= DW'({r_data_sh, spi_din});
                    if (r_dcnt != DCW'(DW)) r_dcnt <= r_dcnt + 1'b1;
                end
                RWAIT: if (r_wcnt != WCW'(TIMEOUT)) r_wcnt <= r_wcnt + 1'b1;
                // A stray high bit mid-frame must not be mistaken for a start bit.
                RESP:  if (!w_tx_busy) r_need_low <= 1'b1;
                default: ;
            endcase

            if (w_do_write) begin
                r_bus_addr    <= (AW+ADDR_LSB)'(r_addr_sh) << ADDR_LSB;
                r_bus_wr_data <= DW'({r_data_sh, spi_din});
                r_bus_we      <= 1'b1;
            end
            if (w_do_read) begin
                r_bus_addr <= (AW+ADDR_LSB)'(r_addr_sh) << ADDR_LSB;
                r_bus_re   <= 1'b1;
                r_wcnt     <= WCW'(1);
            end

            if (overrun_clr)
                r_overrun <= 1'b0;
            else if (spi_din && (r_state == RWAIT || r_state == RESP))
                r_overrun <= 1'b1;
        end
    end

    spi_bus_tx #(.DW(DW)) u_tx (
        .clk      (clk),
        .reset_l  (reset_l),
        .load     (w_tx_load),
        .data     (w_tx_data),
        .status   (w_tx_status),
        .spi_dout (spi_dout),
        .busy     (w_tx_busy)
    );

    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_wr_data = r_bus_wr_data;
    assign bus.bus_we      = r_bus_we;
    assign bus.bus_re      = r_bus_re;
    assign overrun         = r_overrun;
    assign o_dbg_state     = r_state;

endmodule
